// File: rtl/btn_debounce_sync.sv
// ---------------------------------------------------------------------------
// btn_debounce_sync
//   Push-button conditioning between the board pins and the game logic.
//   Each button gets a 2-flop synchroniser, an integrating debounce counter,
//   press/release edge pulses and an optional hold-to-repeat generator.
//   The lowest-index press pulse is encoded into a 3-bit button code one
//   cycle later.
//
// Ports
//   clk          pixel clock, rising edge
//   rst          asynchronous, active-high reset
//   btn_in       raw asynchronous button levels (1 = pressed)
//   btn_level    debounced level per button
//   btn_press    one-cycle pulse per accepted press and per repeat
//   btn_release  one-cycle pulse per accepted release
//   btn_code     index+1 of lowest button that pulsed btn_press last cycle
//   btn_valid    high exactly when btn_code != 0
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// btn_debounce_lane
//   One button: synchroniser, debounce integrator, edge pulses and the
//   repeat state machine.
//
// Ports
//   clk, rst     as top level
//   raw          raw button level
//   level        debounced level
//   press        press / repeat pulse
//   rel          release pulse
// ---------------------------------------------------------------------------
module btn_debounce_lane #(
   parameter int DEBOUNCE_CYCLES = 1485000,
   parameter int REPEAT_EN       = 1,
   parameter int REPEAT_DELAY    = 59400000,
   parameter int REPEAT_PERIOD   = 14850000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic press,
   output logic rel
);

   localparam int DB_W     = $clog2(DEBOUNCE_CYCLES);
   localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int HW_RAW   = $clog2(HOLD_MAX);
   localparam int HW       = (HW_RAW < 1) ? 1 : HW_RAW;

   // ---------------- synchroniser ----------------
   logic s1, s2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   // ---------------- debounce integrator ----------------
   // The counter only runs while the synchronised level disagrees with the
   // accepted level; any return to agreement wipes the accumulated time.
   logic [DB_W-1:0] db_cnt;
   logic            db_diff;
   logic            db_done;
   logic            rise;
   logic            fall;

   assign db_diff = (s2 != level);
   assign db_done = db_diff && (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
   assign rise    = db_done &  s2;
   assign fall    = db_done & ~s2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db_cnt <= '0;
         level  <= 1'b0;
      end else begin
         if (!db_diff || db_done)
            db_cnt <= '0;
         else
            db_cnt <= db_cnt + DB_W'(1);
         if (db_done)
            level <= s2;
      end
   end

   // ---------------- hold-to-repeat ----------------
   logic rpt_fire;

   generate
      if (REPEAT_EN != 0) begin : g_rpt
         localparam logic [1:0] ST_IDLE   = 2'd0;
         localparam logic [1:0] ST_DELAY  = 2'd1;
         localparam logic [1:0] ST_REPEAT = 2'd2;

         logic [1:0]    state, state_nxt;
         logic [HW-1:0] hold_cnt, hold_nxt;
         logic          fire_nxt;

         always_comb begin
            state_nxt = state;
            hold_nxt  = hold_cnt;
            fire_nxt  = 1'b0;
            // An accepted release wins over everything, including a repeat
            // that would have fired on this same edge.
            if (fall) begin
               state_nxt = ST_IDLE;
               hold_nxt  = '0;
            end else if (rise) begin
               state_nxt = ST_DELAY;
               hold_nxt  = '0;
            end else begin
               case (state)
                  ST_DELAY: begin
                     if (hold_cnt == HW'(REPEAT_DELAY - 1)) begin
                        fire_nxt  = 1'b1;
                        state_nxt = ST_REPEAT;
                        hold_nxt  = '0;
                     end else begin
                        hold_nxt  = hold_cnt + HW'(1);
                     end
                  end
                  ST_REPEAT: begin
                     if (hold_cnt == HW'(REPEAT_PERIOD - 1)) begin
                        fire_nxt  = 1'b1;
                        hold_nxt  = '0;
                     end else begin
                        hold_nxt  = hold_cnt + HW'(1);
                     end
                  end
                  default: begin
                     state_nxt = ST_IDLE;
                     hold_nxt  = '0;
                  end
               endcase
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               state    <= ST_IDLE;
               hold_cnt <= '0;
            end else begin
               state    <= state_nxt;
               hold_cnt <= hold_nxt;
            end
         end

         assign rpt_fire = fire_nxt;
      end else begin : g_no_rpt
         assign rpt_fire = 1'b0;
      end
   endgenerate

   // ---------------- edge pulses ----------------
   // Registered on the same edge that updates level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         press <= 1'b0;
         rel   <= 1'b0;
      end else begin
         press <= rise | rpt_fire;
         rel   <= fall;
      end
   end

endmodule

// ---------------------------------------------------------------------------
// btn_debounce_sync (top)
// ---------------------------------------------------------------------------
module btn_debounce_sync #(
   parameter int N_BTN           = 4,
   parameter int DEBOUNCE_CYCLES = 1485000,
   parameter int REPEAT_EN       = 1,
   parameter int REPEAT_DELAY    = 59400000,
   parameter int REPEAT_PERIOD   = 14850000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_in,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [2:0]       btn_code,
   output logic             btn_valid
);

   btn_debounce_lane #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_EN       (REPEAT_EN),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
   ) u_lane [N_BTN-1:0] (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_in),
      .level (btn_level),
      .press (btn_press),
      .rel   (btn_release)
   );

   // Priority encoder: scan from the top down so the lowest index set last.
   // Losing buttons are simply dropped, nothing is queued.
   logic [2:0] code_nxt;

   always_comb begin
      code_nxt = 3'd0;
      for (int i = N_BTN - 1; i >= 0; i--) begin
         if (btn_press[i])
            code_nxt = 3'(i + 1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_code  <= 3'd0;
         btn_valid <= 1'b0;
      end else begin
         btn_code  <= code_nxt;
         btn_valid <= |btn_press;
      end
   end

endmodule

// File: tb/tb_btn_debounce_sync.sv
module tb_btn_debounce_sync;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] btn_in;
   logic [3:0] btn_level;
   logic [3:0] btn_press;
   logic [3:0] btn_release;
   logic [2:0] btn_code;
   logic       btn_valid;

   int n_cmp = 0;
   int n_bad = 0;

   btn_debounce_sync #(
      .N_BTN           (4),
      .DEBOUNCE_CYCLES (4),
      .REPEAT_EN       (1),
      .REPEAT_DELAY    (20),
      .REPEAT_PERIOD   (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_in      (btn_in),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release),
      .btn_code    (btn_code),
      .btn_valid   (btn_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges; return 1 time unit after the last one.
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic quiet(input int n);
      btn_in = 4'b0000;
      tick(n);
   endtask

   int q_p[$];
   int q_r[$];
   int exp_rep[6] = '{6, 26, 34, 42, 50, 58};
   logic [3:0] acc;

   initial begin
      btn_in = 4'b0000;
      rst    = 1'b1;
      tick(2);

      // ---- reset state ----
      chk("rst_level", btn_level, 0);
      chk("rst_press", btn_press, 0);
      chk("rst_rel",   btn_release, 0);
      chk("rst_code",  btn_code, 0);
      chk("rst_valid", btn_valid, 0);
      rst = 1'b0;
      tick(2);

      // ---- clean press on button 2 ----
      btn_in = 4'b0100;
      for (int c = 1; c <= 40; c++) begin
         tick();
         if (c == 5) chk("clean_press_early", btn_press, 4'b0000);
         if (c == 6) begin
            chk("clean_press", btn_press, 4'b0100);
            chk("clean_level", btn_level, 4'b0100);
            chk("clean_code_lag", btn_code, 0);
         end
         if (c == 7) begin
            chk("clean_press_1cyc", btn_press, 4'b0000);
            chk("clean_code", btn_code, 3);
            chk("clean_valid", btn_valid, 1);
         end
         if (c == 8) begin
            chk("clean_code_clr", btn_code, 0);
            chk("clean_valid_clr", btn_valid, 0);
         end
         if (c == 40) chk("clean_level_held", btn_level, 4'b0100);
      end
      btn_in = 4'b0000;
      q_r.delete();
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (btn_release[2]) q_r.push_back(c);
      end
      chk("clean_rel_cnt", q_r.size(), 1);
      chk("clean_rel_at", (q_r.size() > 0) ? q_r[0] : -1, 6);
      chk("clean_level_low", btn_level, 0);
      quiet(10);

      // ---- glitch: 3 cycles high on button 0 ----
      acc = 4'b0000;
      for (int c = 1; c <= 15; c++) begin
         btn_in[0] = (c <= 3);
         tick();
         acc = acc | btn_level | btn_press | btn_release;
      end
      chk("glitch_no_activity", acc, 0);
      chk("glitch_valid", btn_valid, 0);
      quiet(5);

      // ---- bounce then settle on button 1 ----
      q_p.delete();
      acc = 4'b0000;
      for (int c = 1; c <= 30; c++) begin
         btn_in[1] = (c <= 10) ? (((c - 1) / 2) % 2 == 0) : 1'b1;
         tick();
         if (btn_press[1]) q_p.push_back(c);
         acc = acc | btn_press | btn_release;
      end
      chk("bounce_press_cnt", q_p.size(), 1);
      chk("bounce_press_at", (q_p.size() > 0) ? q_p[0] : -1, 14);
      chk("bounce_other_bits", acc, 4'b0010);
      quiet(20);

      // ---- repeat on button 3, held 60 cycles ----
      q_p.delete();
      q_r.delete();
      btn_in = 4'b1000;
      for (int c = 1; c <= 90; c++) begin
         if (c == 61) btn_in = 4'b0000;
         tick();
         if (btn_press[3])   q_p.push_back(c);
         if (btn_release[3]) q_r.push_back(c);
         if (c == 7)  chk("rpt_code", btn_code, 4);
         if (c == 27) chk("rpt_code_rep", btn_code, 4);
      end
      chk("rpt_press_cnt", q_p.size(), 6);
      for (int i = 0; i < 6; i++)
         chk($sformatf("rpt_press_%0d", i), (i < q_p.size()) ? q_p[i] : -1, exp_rep[i]);
      chk("rpt_rel_cnt", q_r.size(), 1);
      chk("rpt_rel_at", (q_r.size() > 0) ? q_r[0] : -1, 66);
      quiet(5);

      // ---- simultaneous press on buttons 1 and 3 ----
      btn_in = 4'b1010;
      tick(5);
      chk("sim_press_early", btn_press, 0);
      tick();
      chk("sim_press", btn_press, 4'b1010);
      tick();
      chk("sim_code", btn_code, 2);
      chk("sim_valid", btn_valid, 1);
      btn_in = 4'b0000;
      tick();
      chk("sim_not_queued_code", btn_code, 0);
      chk("sim_not_queued_valid", btn_valid, 0);
      quiet(15);

      // ---- reset mid-operation with button 0 held ----
      btn_in = 4'b0001;
      tick(15);
      chk("mid_level_pre", btn_level, 4'b0001);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_level", btn_level, 0);
      chk("mid_rst_press", btn_press, 0);
      chk("mid_rst_code", btn_code, 0);
      tick(2);
      rst = 1'b0;
      q_p.delete();
      for (int c = 1; c <= 30; c++) begin
         tick();
         if (btn_press[0]) q_p.push_back(c);
      end
      chk("mid_press_cnt", q_p.size(), 2);
      chk("mid_press_at", (q_p.size() > 0) ? q_p[0] : -1, 6);
      chk("mid_repeat_at", (q_p.size() > 1) ? q_p[1] : -1, 26);
      quiet(10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/btn_debounce_sync.md
# btn_debounce_sync

Conditions the four raw push-button inputs before they reach the game logic. It handles each button separately: a 2-flop synchroniser, an integrating debounce counter, rising and falling edge detection, and optional hold-to-repeat. It also encodes the winning press into a 3-bit button code that matches the game's switch-code width. It sits between the board pins and the switch/state/game path, in the pixel-clock domain.

## Interface
- N_BTN, 4, number of buttons; fixed at 4 while btn_code is 3 bits.
- DEBOUNCE_CYCLES, 1485000, cycles a synchronised level must hold before it is accepted (10 ms at 148.5 MHz). Minimum 2.
- REPEAT_EN, 1, enables hold-to-repeat when 1.
- REPEAT_DELAY, 59400000, cycles from the accepted press to the first repeat pulse (400 ms).
- REPEAT_PERIOD, 14850000, cycles between later repeat pulses (100 ms).
- clk  in  1  pixel clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- btn_in  in  N_BTN  raw, asynchronous button levels; 1 = pressed.
- btn_level  out  N_BTN  debounced level per button.
- btn_press  out  N_BTN  one-cycle pulse on each accepted press and on each repeat.
- btn_release  out  N_BTN  one-cycle pulse on each accepted release.
- btn_code  out  3  index+1 of the lowest-index button pulsing on btn_press in the previous cycle; 0 when none.
- btn_valid  out  1  one-cycle strobe, high exactly when btn_code != 0.

## Operation
- Reset state: all sync flops, counters, btn_level, btn_press, btn_release, btn_code and btn_valid are 0.
- Synchroniser: s1 <= btn_in[i]; s2 <= s1.
- Debounce counter, one per button, width $clog2(DEBOUNCE_CYCLES):
  - If s2 == btn_level[i], the counter clears to 0.
  - Otherwise it increments.
  - When it equals DEBOUNCE_CYCLES-1 and s2 still differs, btn_level[i] <= s2 and the counter clears.
- Glitches: any excursion shorter than DEBOUNCE_CYCLES cycles at s2 clears the counter when s2 returns. It produces no output change.
- Edge pulses: registered on the same edge as the btn_level update. A 0→1 update gives btn_press[i]=1 for one cycle; a 1→0 update gives btn_release[i]=1 for one cycle.
- Repeat state machine per button, active only when REPEAT_EN=1:
  - IDLE: btn_level=0, hold counter 0.
  - On an accepted press, go to DELAY and clear the hold counter.
  - DELAY: count. At REPEAT_DELAY-1, pulse btn_press[i], clear the counter and go to REPEAT.
  - REPEAT: count. At REPEAT_PERIOD-1, pulse btn_press[i] and clear the counter.
  - From any state, btn_level going to 0 returns to IDLE and clears the counter. No further repeat pulse is issued, even if the counter was at terminal count on that edge.
  - Hold counter width is $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)).
- Encoder: on each edge, btn_code <= index+1 of the lowest set bit of the current btn_press, and btn_valid <= |btn_press.
  - Lower index wins when several buttons pulse together.
  - Losing buttons still appear on btn_press but are not queued.
- A button held through reset is seen as a new press after reset deasserts.

## Timing
- Let edge E0 be the first clock edge that samples the new btn_in level into s1, with the level held stable.
- btn_level and btn_press/btn_release change at edge E0+1+DEBOUNCE_CYCLES, and the pulse is high for the following cycle.
- btn_code and btn_valid follow btn_press by exactly one cycle.
- With repeat enabled and the button held:
  - first repeat pulse REPEAT_DELAY cycles after the press pulse;
  - later repeats every REPEAT_PERIOD cycles.
- Reset is asynchronous: outputs go to 0 immediately, and a pulse in flight is dropped. Release of rst is assumed to be synchronised upstream.
- Counters never wrap: each clears at terminal count or when its level matches.

## Test plan
Parameters for the bench: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
- **Clean press:** btn_in[2] goes 0→1 and is held 40 cycles.
  - btn_press[2] pulses at E0+5, then btn_code=3 with btn_valid=1 one cycle later.
  - btn_level[2]=1 until the button is released.
- **Glitch:** btn_in[0] high for 3 cycles, then low. btn_level stays 0 and no pulses occur.
- **Bounce then settle:** btn_in[1] toggles every 2 cycles for 10 cycles, then holds 1. Exactly one press pulse, 5 cycles after the final toggle.
- **Repeat:** btn_in[3] held 60 cycles.
  - Press pulse, then repeats at +20, +28, +36, +44, +52 cycles.
  - After release, one btn_release[3] pulse and no further press pulses.
- **Simultaneous:** btn_in[1] and btn_in[3] rise on the same edge.
  - Both btn_press bits pulse together.
  - btn_code=2 with btn_valid=1, and nothing is queued for button 3.
- **Reset mid-operation:** rst pulsed while btn_in[0] is held and the repeat counter is mid-count.
  - All outputs 0 immediately.
  - After reset, a new press pulse at E0+5 and the repeat sequence restarts from DELAY.
